// File: rtl/addr_gen_pkg.sv
// Shared types and constants for the multipass merge-sort address generator.
// Default geometry is expressed as log2 values so every power-of-2 size derives from them.
package addr_gen_pkg;

   localparam int LOG2N     = 2;
   localparam int LOG2BURST = 10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_CMD  = 3'd1,
      S_RD_CMD  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_WR_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   typedef struct packed {
      logic divide;
      logic last_round;
   } rd_flags_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/addr_gen_pass_param.sv
// Per-pass geometry: derives channel size, divide flag, 64B run count and round stride
// from the current sorted-run size.
module addr_gen_pass_param
   import addr_gen_pkg::*;
#(
   parameter int NUM_READ_CHANNELS  = 4,
   parameter int C_XFER_SIZE_WIDTH  = 64,
   parameter int C_BURST_SIZE_BYTES = 1024
) (
   input  logic [C_XFER_SIZE_WIDTH-1:0] run_bytes,
   output logic [C_XFER_SIZE_WIDTH-1:0] chan_bytes,
   output logic                         divide,
   output logic [C_XFER_SIZE_WIDTH-1:0] run_count,
   output logic [C_XFER_SIZE_WIDTH-1:0] stride
);

   localparam int LOG2_N = clog2(NUM_READ_CHANNELS);
   localparam logic [C_XFER_SIZE_WIDTH-1:0] BURST_BYTES = C_XFER_SIZE_WIDTH'(C_BURST_SIZE_BYTES);

   // runs shorter than a burst are packed several per burst, so a channel still reads one burst
   always_comb begin
      divide = (run_bytes < BURST_BYTES);
      if (divide) begin
         chan_bytes = BURST_BYTES;
      end else begin
         chan_bytes = run_bytes;
      end
      run_count = run_bytes >> 6;
      stride    = chan_bytes << LOG2_N;
   end

endmodule

// File: rtl/addr_gen_multipass.sv
// Pass/round address generator for the multipass merge sort (top level).
// Optional ADDR_GEN_PERF_CNT_EN adds live cycle counters on the perf_* ports.
module addr_gen_multipass
   import addr_gen_pkg::*;
#(
   parameter int NUM_READ_CHANNELS  = 32'd1 << LOG2N,
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_XFER_SIZE_WIDTH  = 64,
   parameter int C_BURST_SIZE_BYTES = 32'd1 << LOG2BURST,
   parameter int C_INIT_RUN_BYTES   = 64,
   parameter int C_PASS_CNT_WIDTH   = 8
) (
   input  logic                                          aclk,
   input  logic                                          areset,
   input  logic                                          ap_start,
   output logic                                          ap_done,
   input  logic [C_PASS_CNT_WIDTH-1:0]                   num_pass,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]                 in_addr_offset,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]                 out_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]                  in_xfer_size_in_bytes,
   output logic                                          rd_cmd_valid,
   input  logic                                          rd_cmd_ready,
   output logic [NUM_READ_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] read_addr,
   output logic [C_XFER_SIZE_WIDTH-1:0]                  read_size_in_bytes,
   output logic                                          read_divide,
   output logic [C_XFER_SIZE_WIDTH-1:0]                  read_run_count,
   output logic                                          read_last_round,
   input  logic                                          read_done,
   output logic                                          wr_cmd_valid,
   input  logic                                          wr_cmd_ready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]                 write_addr,
   input  logic                                          write_done,
   output logic [C_PASS_CNT_WIDTH-1:0]                   pass_idx,
   output logic                                          result_in_out,
   output logic                                          busy,
   output logic                                          err,
   output logic [31:0]                                   perf_pass_cycles,
   output logic [31:0]                                   perf_total_cycles
);

   localparam int AW     = C_M_AXI_ADDR_WIDTH;
   localparam int XW     = C_XFER_SIZE_WIDTH;
   localparam int PCW    = C_PASS_CNT_WIDTH;
   localparam int LOG2_N = clog2(NUM_READ_CHANNELS);

   state_t          state_r, state_nxt_s;
   logic [PCW-1:0]  pass_r, num_pass_r, pass_inc_s;
   logic [AW-1:0]   src_base_r, dst_base_r, src_r, addr_acc_s;
   logic [XW-1:0]   size_r, run_bytes_r, total_r, total_adv_s;
   logic [XW-1:0]   run_shift_s, run_cap_s, run_nxt_s;
   logic [XW-1:0]   chan_bytes_s, run_count_s, stride_s;
   logic            divide_s;
   logic            err_r, err_nxt_s, ap_done_r, result_r;
   logic            start_accept_s, rd_take_s, wr_take_s, stray_s;
   rd_flags_t       rd_flags_s;

   addr_gen_pass_param #(
      .NUM_READ_CHANNELS  (NUM_READ_CHANNELS),
      .C_XFER_SIZE_WIDTH  (XW),
      .C_BURST_SIZE_BYTES (C_BURST_SIZE_BYTES)
   ) u_pass_param (
      .run_bytes  (run_bytes_r),
      .chan_bytes (chan_bytes_s),
      .divide     (divide_s),
      .run_count  (run_count_s),
      .stride     (stride_s)
   );

   assign start_accept_s = ap_start & (state_r == S_IDLE);
   assign rd_take_s      = read_done & (state_r == S_RD_WAIT);
   assign wr_take_s      = write_done & (state_r == S_WR_WAIT);
   assign stray_s        = (read_done & (state_r != S_RD_WAIT)) | (write_done & (state_r != S_WR_WAIT));
   assign total_adv_s    = total_r + stride_s;
   assign pass_inc_s     = pass_r + PCW'(1'b1);
   assign run_shift_s    = run_bytes_r << LOG2_N;
   assign run_cap_s      = size_r >> LOG2_N;

   // run size for the next pass; the final pass merges N runs covering the whole buffer
   always_comb begin
      if ((pass_inc_s == (num_pass_r - PCW'(1'b1))) || (run_shift_s > run_cap_s)) begin
         run_nxt_s = run_cap_s;
      end else begin
         run_nxt_s = run_shift_s;
      end
   end

   // sticky error: cleared by an accepted start unless a stray pulse lands in the same cycle
   always_comb begin
      if (start_accept_s) begin
         err_nxt_s = stray_s;
      end else begin
         err_nxt_s = err_r | stray_s;
      end
   end

   // pass/round next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (ap_start) begin
               if (num_pass == '0) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_WR_CMD;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WR_CMD: begin
            if (wr_cmd_ready) begin
               state_nxt_s = S_RD_CMD;
            end else begin
               state_nxt_s = S_WR_CMD;
            end
         end
         S_RD_CMD: begin
            if (rd_cmd_ready) begin
               state_nxt_s = S_RD_WAIT;
            end else begin
               state_nxt_s = S_RD_CMD;
            end
         end
         S_RD_WAIT: begin
            if (!read_done) begin
               state_nxt_s = S_RD_WAIT;
            end else if (total_adv_s >= size_r) begin
               state_nxt_s = S_WR_WAIT;
            end else begin
               state_nxt_s = S_RD_CMD;
            end
         end
         S_WR_WAIT: begin
            if (!write_done) begin
               state_nxt_s = S_WR_WAIT;
            end else if (pass_inc_s == num_pass_r) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_WR_CMD;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // state, latched configuration and per-pass progress
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r     <= S_IDLE;
         pass_r      <= '0;
         num_pass_r  <= '0;
         src_base_r  <= '0;
         dst_base_r  <= '0;
         src_r       <= '0;
         size_r      <= '0;
         run_bytes_r <= '0;
         total_r     <= '0;
         err_r       <= 1'b0;
         ap_done_r   <= 1'b0;
         result_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         err_r     <= err_nxt_s;
         ap_done_r <= (state_r == S_DONE);
         if (start_accept_s) begin
            pass_r      <= '0;
            num_pass_r  <= num_pass;
            src_base_r  <= in_addr_offset;
            dst_base_r  <= out_addr_offset;
            src_r       <= in_addr_offset;
            size_r      <= in_xfer_size_in_bytes;
            run_bytes_r <= XW'(C_INIT_RUN_BYTES);
            total_r     <= '0;
            result_r    <= 1'b0;
         end else begin
            if (state_r == S_DONE) begin
               result_r <= num_pass_r[0];
            end
            if (rd_take_s) begin
               total_r <= total_adv_s;
               src_r   <= src_r + AW'(stride_s);
            end
            if (wr_take_s) begin
               pass_r <= pass_inc_s;
               if (pass_inc_s != num_pass_r) begin
                  src_base_r  <= dst_base_r;
                  dst_base_r  <= src_base_r;
                  src_r       <= dst_base_r;
                  total_r     <= '0;
                  run_bytes_r <= run_nxt_s;
               end
            end
         end
      end
   end

   // read command fields, driven only while the command is offered
   always_comb begin
      addr_acc_s         = src_r;
      read_addr          = '0;
      read_size_in_bytes = '0;
      read_run_count     = '0;
      rd_flags_s         = '0;
      if (state_r == S_RD_CMD) begin
         for (int i = 0; i < NUM_READ_CHANNELS; i++) begin
            read_addr[i*AW +: AW] = addr_acc_s;
            addr_acc_s            = addr_acc_s + AW'(chan_bytes_s);
         end
         read_size_in_bytes    = chan_bytes_s;
         read_run_count        = run_count_s;
         rd_flags_s.divide     = divide_s;
         rd_flags_s.last_round = (total_adv_s >= size_r);
      end else begin
         addr_acc_s = src_r;
      end
   end

   assign read_divide     = rd_flags_s.divide;
   assign read_last_round = rd_flags_s.last_round;
   assign rd_cmd_valid    = (state_r == S_RD_CMD);
   assign wr_cmd_valid    = (state_r == S_WR_CMD);
   assign write_addr      = dst_base_r;
   assign pass_idx        = pass_r;
   assign busy            = (state_r != S_IDLE);
   assign err             = err_r;
   assign ap_done         = ap_done_r;
   assign result_in_out   = result_r;

`ifdef ADDR_GEN_PERF_CNT_EN
   logic [31:0] pass_cyc_r, pass_last_r, total_cyc_r;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // saturating cycle counters for the running pass and the whole job
   always_ff @(posedge aclk) begin
      if (areset || start_accept_s) begin
         pass_cyc_r  <= 32'd0;
         pass_last_r <= 32'd0;
         total_cyc_r <= 32'd0;
      end else begin
         if (state_r != S_IDLE) begin
            total_cyc_r <= sat_inc(total_cyc_r);
         end
         if (wr_take_s) begin
            pass_last_r <= sat_inc(pass_cyc_r);
            pass_cyc_r  <= 32'd0;
         end else if (state_r != S_IDLE) begin
            pass_cyc_r <= sat_inc(pass_cyc_r);
         end
      end
   end

   assign perf_pass_cycles  = pass_last_r;
   assign perf_total_cycles = total_cyc_r;
`else
   assign perf_pass_cycles  = 32'd0;
   assign perf_total_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_addr_gen_multipass.sv
// Directed bench for addr_gen_multipass: N=4, S=16384, table of expected read rounds.
module tb_addr_gen_multipass;

   localparam logic [63:0] IN_BASE  = 64'h1000_0000;
   localparam logic [63:0] OUT_BASE = 64'h2000_0000;
   localparam logic [63:0] S_BYTES  = 64'd16384;

   logic         aclk = 1'b0;
   logic         areset, ap_start, ap_done;
   logic [7:0]   num_pass;
   logic [63:0]  in_addr_offset, out_addr_offset, in_xfer_size_in_bytes;
   logic         rd_cmd_valid, rd_cmd_ready;
   logic [255:0] read_addr;
   logic [63:0]  read_size_in_bytes, read_run_count, write_addr;
   logic         read_divide, read_last_round, read_done;
   logic         wr_cmd_valid, wr_cmd_ready, write_done;
   logic [7:0]   pass_idx;
   logic         result_in_out, busy, err;
   logic [31:0]  perf_pass_cycles, perf_total_cycles;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic exp_result;

   typedef struct {
      int          pass;
      bit          first;
      bit          last;
      logic [63:0] wr_addr;
      logic [63:0] addr0;
      logic [63:0] addr3;
      logic [63:0] size;
      logic [63:0] run_count;
      bit          divide;
      int          wr_stall;
      int          rd_stall;
      bit          poke;
      bit          stray;
   } vec_t;

   vec_t vecs[13];

   addr_gen_multipass dut (
      .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
      .num_pass(num_pass), .in_addr_offset(in_addr_offset), .out_addr_offset(out_addr_offset),
      .in_xfer_size_in_bytes(in_xfer_size_in_bytes),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .read_addr(read_addr),
      .read_size_in_bytes(read_size_in_bytes), .read_divide(read_divide),
      .read_run_count(read_run_count), .read_last_round(read_last_round), .read_done(read_done),
      .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .write_addr(write_addr),
      .write_done(write_done), .pass_idx(pass_idx), .result_in_out(result_in_out),
      .busy(busy), .err(err), .perf_pass_cycles(perf_pass_cycles),
      .perf_total_cycles(perf_total_cycles)
   );

   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      if (ap_done === 1'b1) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int k, input int p, input int r, input int nr,
                          input logic [63:0] src, input logic [63:0] dst,
                          input logic [63:0] size, input logic [63:0] rc, input bit div);
      vecs[k].pass      = p;
      vecs[k].first     = (r == 0);
      vecs[k].last      = (r == nr - 1);
      vecs[k].wr_addr   = dst;
      vecs[k].addr0     = src + 64'h1000 * r;
      vecs[k].addr3     = src + 64'h1000 * r + 64'd3 * size;
      vecs[k].size      = size;
      vecs[k].run_count = rc;
      vecs[k].divide    = div;
      vecs[k].wr_stall  = 0;
      vecs[k].rd_stall  = 0;
      vecs[k].poke      = 1'b0;
      vecs[k].stray     = 1'b0;
   endtask

   task automatic wait_valid(input bit rd, input string nm);
      int n;
      n = 0;
      while (((rd ? rd_cmd_valid : wr_cmd_valid) !== 1'b1) && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk(nm, 64'(n < 50), 64'd1);
   endtask

   task automatic chk_rd(input int k, input string tag);
      chk($sformatf("%s_addr0[%0d]", tag, k), read_addr[63:0], vecs[k].addr0);
      chk($sformatf("%s_addr3[%0d]", tag, k), read_addr[255:192], vecs[k].addr3);
      chk($sformatf("%s_size[%0d]", tag, k), read_size_in_bytes, vecs[k].size);
      chk($sformatf("%s_divide[%0d]", tag, k), 64'(read_divide), 64'(vecs[k].divide));
      chk($sformatf("%s_runcnt[%0d]", tag, k), read_run_count, vecs[k].run_count);
      chk($sformatf("%s_last[%0d]", tag, k), 64'(read_last_round), 64'(vecs[k].last));
      chk($sformatf("%s_pass[%0d]", tag, k), 64'(pass_idx), 64'(vecs[k].pass));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_ap_done"}, 64'(ap_done), 64'd0);
      chk({tag, "_rd_valid"}, 64'(rd_cmd_valid), 64'd0);
      chk({tag, "_wr_valid"}, 64'(wr_cmd_valid), 64'd0);
      chk({tag, "_read_addr_hi"}, read_addr[255:192], 64'd0);
      chk({tag, "_read_addr_lo"}, read_addr[63:0], 64'd0);
      chk({tag, "_size"}, read_size_in_bytes, 64'd0);
      chk({tag, "_divide"}, 64'(read_divide), 64'd0);
      chk({tag, "_runcnt"}, read_run_count, 64'd0);
      chk({tag, "_last"}, 64'(read_last_round), 64'd0);
      chk({tag, "_write_addr"}, write_addr, 64'd0);
      chk({tag, "_pass_idx"}, 64'(pass_idx), 64'd0);
      chk({tag, "_result"}, 64'(result_in_out), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_perf"}, {perf_pass_cycles, perf_total_cycles}, 64'd0);
   endtask

   task automatic start_run(input logic [7:0] np, input logic exp_res);
      num_pass              = np;
      in_addr_offset        = IN_BASE;
      out_addr_offset       = OUT_BASE;
      in_xfer_size_in_bytes = S_BYTES;
      exp_result            = exp_res;
      done_cnt              = 0;
      ap_start = 1'b1;
      @(negedge aclk);
      ap_start = 1'b0;
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_err_clear", 64'(err), 64'd0);
      chk("start_wr_valid", 64'(wr_cmd_valid), 64'(np != 8'd0));
      chk("start_rd_valid", 64'(rd_cmd_valid), 64'd0);
      chk("start_pass", 64'(pass_idx), 64'd0);
   endtask

   task automatic do_wr(input int k);
      wait_valid(1'b0, $sformatf("wr_wait[%0d]", k));
      chk($sformatf("wr_addr[%0d]", k), write_addr, vecs[k].wr_addr);
      chk($sformatf("wr_pass[%0d]", k), 64'(pass_idx), 64'(vecs[k].pass));
      for (int c = 0; c < vecs[k].wr_stall; c++) begin
         @(negedge aclk);
         chk($sformatf("wr_stall_valid[%0d]", k), 64'(wr_cmd_valid), 64'd1);
         chk($sformatf("wr_stall_addr[%0d]", k), write_addr, vecs[k].wr_addr);
      end
      wr_cmd_ready = 1'b1;
      @(negedge aclk);
      wr_cmd_ready = 1'b0;
      chk($sformatf("wr_one_xfer[%0d]", k), 64'(wr_cmd_valid), 64'd0);
      chk($sformatf("wr_to_rd[%0d]", k), 64'(rd_cmd_valid), 64'd1);
   endtask

   task automatic do_rd_cmd(input int k);
      wait_valid(1'b1, $sformatf("rd_wait[%0d]", k));
      chk_rd(k, "rd");
      for (int c = 0; c < vecs[k].rd_stall; c++) begin
         if (vecs[k].poke && c == 0) begin
            ap_start       = 1'b1;
            num_pass       = 8'd1;
            in_addr_offset = 64'hDEAD_0000;
         end
         @(negedge aclk);
         ap_start = 1'b0;
         chk($sformatf("rd_stall_valid[%0d]", k), 64'(rd_cmd_valid), 64'd1);
         chk_rd(k, "rd_stall");
      end
      rd_cmd_ready = 1'b1;
      @(negedge aclk);
      rd_cmd_ready = 1'b0;
      chk($sformatf("rd_one_xfer[%0d]", k), 64'(rd_cmd_valid), 64'd0);
   endtask

   task automatic do_rd_done(input int k);
      repeat (2) @(negedge aclk);
      read_done = 1'b1;
      @(negedge aclk);
      read_done = 1'b0;
      if (!vecs[k].last) begin
         chk($sformatf("rd_next_lat[%0d]", k), 64'(rd_cmd_valid), 64'd1);
      end else begin
         chk($sformatf("wrwait_rd[%0d]", k), 64'(rd_cmd_valid), 64'd0);
         chk($sformatf("wrwait_wr[%0d]", k), 64'(wr_cmd_valid), 64'd0);
         chk($sformatf("wrwait_busy[%0d]", k), 64'(busy), 64'd1);
      end
   endtask

   task automatic finish_pass(input int k, input bit fin);
      if (vecs[k].stray) begin
         chk("stray_err_before", 64'(err), 64'd0);
         read_done = 1'b1;
         @(negedge aclk);
         read_done = 1'b0;
         chk("stray_err_set", 64'(err), 64'd1);
         chk("stray_busy", 64'(busy), 64'd1);
         chk("stray_no_rd", 64'(rd_cmd_valid), 64'd0);
         chk("stray_no_wr", 64'(wr_cmd_valid), 64'd0);
         chk("stray_pass", 64'(pass_idx), 64'(vecs[k].pass));
      end
      write_done = 1'b1;
      @(negedge aclk);
      write_done = 1'b0;
      if (!fin) begin
         chk($sformatf("wr_next_lat[%0d]", k), 64'(wr_cmd_valid), 64'd1);
         chk($sformatf("pass_inc[%0d]", k), 64'(pass_idx), 64'(vecs[k].pass + 1));
      end else begin
         chk("done_busy", 64'(busy), 64'd1);
         chk("done_early", 64'(ap_done), 64'd0);
         @(negedge aclk);
         chk("ap_done", 64'(ap_done), 64'd1);
         chk("done_idle", 64'(busy), 64'd0);
         chk("result_in_out", 64'(result_in_out), 64'(exp_result));
      end
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         if (vecs[k].first) do_wr(k);
         do_rd_cmd(k);
         do_rd_done(k);
         if (vecs[k].last) finish_pass(k, k == hi);
      end
   endtask

   initial begin
      for (int r = 0; r < 4; r++) set_vec(r,     0, r, 4, IN_BASE,  OUT_BASE, 64'd1024, 64'd1,  1'b1);
      for (int r = 0; r < 4; r++) set_vec(4 + r, 1, r, 4, OUT_BASE, IN_BASE,  64'd1024, 64'd4,  1'b1);
      for (int r = 0; r < 4; r++) set_vec(8 + r, 2, r, 4, IN_BASE,  OUT_BASE, 64'd1024, 64'd16, 1'b0);
      set_vec(12, 3, 0, 1, OUT_BASE, IN_BASE, 64'd4096, 64'd64, 1'b0);
      vecs[5].rd_stall = 5;
      vecs[5].poke     = 1'b1;
      vecs[8].wr_stall = 5;
      vecs[7].stray    = 1'b1;

      areset = 1'b1; ap_start = 1'b0; num_pass = 8'd0;
      in_addr_offset = 64'd0; out_addr_offset = 64'd0; in_xfer_size_in_bytes = 64'd0;
      rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; read_done = 1'b0; write_done = 1'b0;
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check_all_zero("reset");

      // zero passes: straight to DONE, no commands
      start_run(8'd0, 1'b0);
      chk("np0_ap_done_early", 64'(ap_done), 64'd0);
      @(negedge aclk);
      chk("np0_ap_done", 64'(ap_done), 64'd1);
      chk("np0_idle", 64'(busy), 64'd0);
      chk("np0_no_wr", 64'(wr_cmd_valid), 64'd0);
      repeat (3) @(negedge aclk);
      chk("np0_done_once", 64'(done_cnt), 64'd1);

      // four-pass run with stalls, a stray read_done and an ignored ap_start
      start_run(8'd4, 1'b0);
      run_vecs(0, 12);
      repeat (3) @(negedge aclk);
      chk("main_done_once", 64'(done_cnt), 64'd1);
      chk("err_sticky", 64'(err), 64'd1);

      // reset in the middle of RD_WAIT
      start_run(8'd4, 1'b0);
      do_wr(0);
      do_rd_cmd(0);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      check_all_zero("rst_mid");

      // fresh single-pass run: result lands in out buffer
      start_run(8'd1, 1'b1);
      run_vecs(0, 3);
      repeat (3) @(negedge aclk);
      chk("np1_done_once", 64'(done_cnt), 64'd1);
      chk("np1_err", 64'(err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
